// File: rtl/robin_pkg.sv
// Shared definitions for the robin CPU memory path: access sizes, the
// load/store sequencer state encoding and the load extension helper.
`default_nettype none

package robin_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    // Keeps the low nbytes bytes of value and fills the rest with zeros or
    // with the top bit of the kept field.
    function automatic logic [63:0] extend(input logic [63:0] value,
                                           input int unsigned nbytes,
                                           input logic        is_signed);
        logic [63:0] mask;
        logic [63:0] shifted;
        logic        sbit;
        if (nbytes == 0) begin
            return 64'd0;
        end
        if (nbytes >= 8) begin
            mask = '1;
        end else begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
        end
        shifted = value >> (8 * nbytes - 1);
        sbit    = is_signed & shifted[0];
        return (value & mask) | (sbit ? ~mask : 64'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns one CPU memory request into a big-endian
// series of byte accesses on an 8-bit memory port with fixed read latency.
`default_nettype none

module mem_access_unit
    import robin_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_BYTES = 4,
    parameter int RD_LAT     = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [$clog2(WORD_BYTES):0]     req_size,
    input  logic                            req_signed,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [8*WORD_BYTES-1:0]         req_wdata,
    output logic                            resp_valid,
    output logic [8*WORD_BYTES-1:0]         resp_rdata,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           mem_raddr,
    input  logic [7:0]                      mem_data_out,
    output logic [ADDR_WIDTH-1:0]           mem_waddr,
    output logic [7:0]                      mem_data_in,
    output logic                            mem_write,
    input  logic                            mem_ready
);

    localparam int LOG2WB = $clog2(WORD_BYTES);
    localparam int SW     = LOG2WB + 1;
    localparam int DW     = 8 * WORD_BYTES;
    localparam int CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           k_q, k_d;
    logic [SW-1:0]           last_q, last_d;
    logic                    signed_q, signed_d;
    logic [DW-1:0]           wdata_q, wdata_d;
    logic [DW-1:0]           asm_q, asm_d;
    logic [DW-1:0]           resp_rdata_q, resp_rdata_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_raddr_q, mem_raddr_d;
    logic [ADDR_WIDTH-1:0]   mem_waddr_q, mem_waddr_d;
    logic [7:0]              mem_data_in_q, mem_data_in_d;
    logic                    mem_write_q, mem_write_d;

    logic [SW-1:0]           w_size_eff;
    int unsigned             w_jshift;
    logic [DW-1:0]           w_wsh;
    logic [DW-1:0]           w_asm_next;
    logic [63:0]             w_ext;

    // Store data is left-justified so the first byte to send is always on top.
    always_comb begin
        w_size_eff = (req_size > SW'(LOG2WB)) ? SW'(LOG2WB) : req_size;
        w_jshift   = 8 * (32'(WORD_BYTES) - (32'd1 << w_size_eff));
        w_wsh      = req_wdata << w_jshift;
        w_asm_next = (asm_q << 8) | DW'(mem_data_out);
        w_ext      = extend(64'(w_asm_next), 32'(last_q) + 32'd1, signed_q);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        last_d        = last_q;
        signed_d      = signed_q;
        wdata_d       = wdata_q;
        asm_d         = asm_q;
        resp_rdata_d  = resp_rdata_q;
        resp_valid_d  = 1'b0;
        mem_raddr_d   = mem_raddr_q;
        mem_waddr_d   = mem_waddr_q;
        mem_data_in_d = mem_data_in_q;
        mem_write_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    last_d   = SW'((32'd1 << w_size_eff) - 32'd1);
                    signed_d = req_signed;
                    k_d      = '0;
                    cnt_d    = '0;
                    asm_d    = '0;
                    if (req_write) begin
                        mem_waddr_d   = req_addr;
                        mem_data_in_d = w_wsh[DW-1 -: 8];
                        wdata_d       = w_wsh << 8;
                        state_d       = ST_WR_SETUP;
                    end else begin
                        mem_raddr_d = req_addr;
                        state_d     = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    // A stalled capture keeps the counter at its final value.
                    if (mem_ready) begin
                        asm_d       = w_asm_next;
                        mem_raddr_d = mem_raddr_q + ADDR_WIDTH'(1);
                        cnt_d       = '0;
                        if (k_q == last_q) begin
                            resp_rdata_d = w_ext[DW-1:0];
                            resp_valid_d = 1'b1;
                            state_d      = ST_RESP;
                        end else begin
                            k_d = k_q + SW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WR_SETUP: begin
                if (mem_ready) begin
                    mem_write_d = 1'b1;
                    state_d     = ST_WR_PULSE;
                end
            end
            ST_WR_PULSE: begin
                if (k_q == last_q) begin
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    mem_waddr_d   = mem_waddr_q + ADDR_WIDTH'(1);
                    mem_data_in_d = wdata_q[DW-1 -: 8];
                    wdata_d       = wdata_q << 8;
                    k_d           = k_q + SW'(1);
                    state_d       = ST_WR_SETUP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            k_q           <= '0;
            last_q        <= '0;
            signed_q      <= 1'b0;
            wdata_q       <= '0;
            asm_q         <= '0;
            resp_rdata_q  <= '0;
            resp_valid_q  <= 1'b0;
            mem_raddr_q   <= '0;
            mem_waddr_q   <= '0;
            mem_data_in_q <= '0;
            mem_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            last_q        <= last_d;
            signed_q      <= signed_d;
            wdata_q       <= wdata_d;
            asm_q         <= asm_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_valid_q  <= resp_valid_d;
            mem_raddr_q   <= mem_raddr_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_write_q   <= mem_write_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = ~req_ready;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_raddr   = mem_raddr_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_write   = mem_write_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected writes and responses are
// queued at issue time and checked by independent monitors.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_unit;

    localparam int AW = 9;
    localparam int WB = 4;
    localparam int RL = 2;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [2:0]      req_size;
    logic            req_signed;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic            resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            busy;
    logic [AW-1:0]   mem_raddr;
    logic [7:0]      mem_data_out;
    logic [AW-1:0]   mem_waddr;
    logic [7:0]      mem_data_in;
    logic            mem_write;
    logic            mem_ready;

    mem_access_unit #(.ADDR_WIDTH(AW), .WORD_BYTES(WB), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .busy(busy), .mem_raddr(mem_raddr), .mem_data_out(mem_data_out),
        .mem_waddr(mem_waddr), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stall_lo = -1;
    int stall_hi = -1;
    assign mem_ready = !(cyc >= stall_lo && cyc < stall_hi);

    // Memory with one register stage: data for an address set at an edge is
    // valid during the second cycle after it, matching RD_LAT=2.
    logic [7:0] mem [0:511];
    logic [7:0] rd_pipe;
    always @(posedge clk) rd_pipe <= mem[mem_raddr];
    assign mem_data_out = rd_pipe;

    typedef struct { logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic [8:0] addr; logic [7:0] data; int cyc; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];
    resp_t er;
    wr_t   ew;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (mem_write) begin
            check("write_not_consecutive", 64'(prev_wr), 64'd0);
            if (wr_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_write: addr %0h data %0h cyc %0d", mem_waddr, mem_data_in, cyc);
            end else begin
                ew = wr_q.pop_front();
                check("wr_addr", 64'(mem_waddr), 64'(ew.addr));
                check("wr_data", 64'(mem_data_in), 64'(ew.data));
                check("wr_cycle", 64'(cyc), 64'(ew.cyc));
            end
        end
        prev_wr = mem_write;
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_resp: rdata %0h cyc %0d", resp_rdata, cyc);
            end else begin
                er = resp_q.pop_front();
                check("resp_rdata", 64'(resp_rdata), 64'(er.data));
                check("resp_cycle", 64'(cyc), 64'(er.cyc));
            end
        end
    end

    // Returns the cycle-1 index a: cycle n of the transaction has cyc == a+n-1.
    task automatic issue(input logic wr, input logic [2:0] sz, input logic sg,
                         input logic [8:0] addr, input logic [31:0] wd, output int a);
        int t;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        a = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((resp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 100) begin
            n_err++;
            $display("FAIL %s_timeout: pending resp %0d wr %0d", name, resp_q.size(), wr_q.size());
        end
        stall_lo = -1;
        stall_hi = -1;
    endtask

    // Load of nb bytes; optional stall of slen cycles at byte sb's capture.
    task automatic do_load(input string name, input logic [2:0] sz, input logic sg,
                           input logic [8:0] addr, input int nb, input logic [31:0] exp,
                           input int sb, input int slen);
        int a;
        issue(1'b0, sz, sg, addr, 32'h0, a);
        if (slen > 0) begin
            stall_lo = a + RL * (sb + 1) - 1;
            stall_hi = stall_lo + slen;
        end
        resp_q.push_back('{data: exp, cyc: a + RL * nb + slen});
        last_rd = exp;
        wait_done(name);
    endtask

    task automatic do_store(input string name, input logic [2:0] sz,
                            input logic [8:0] addr, input int nb, input logic [31:0] wd,
                            input int sb, input int slen);
        int a;
        logic [31:0] v;
        logic [8:0]  ad;
        v = wd;
        issue(1'b1, sz, 1'b0, addr, wd, a);
        if (slen > 0) begin
            stall_lo = a + 2 * sb;
            stall_hi = stall_lo + slen;
        end
        for (int k = 0; k < nb; k++) begin
            ad = addr + 9'(k);
            wr_q.push_back('{addr: ad, data: v[8*(nb-1-k) +: 8],
                             cyc: a + 2 * k + 1 + ((k >= sb && slen > 0) ? slen : 0)});
        end
        resp_q.push_back('{data: last_rd, cyc: a + 2 * nb + slen});
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h010] = 8'h81; mem[9'h011] = 8'h22; mem[9'h012] = 8'h33; mem[9'h013] = 8'h44;
        mem[9'h1FF] = 8'hAB; mem[9'h000] = 8'hCD;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 3'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_mem_raddr", 64'(mem_raddr), 64'd0);
        check("rst_mem_waddr", 64'(mem_waddr), 64'd0);
        check("rst_mem_data_in", 64'(mem_data_in), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);

        do_load("word_load", 3'd2, 1'b0, 9'h010, 4, 32'h81223344, 0, 0);
        do_load("clamp_load", 3'd3, 1'b0, 9'h010, 4, 32'h81223344, 0, 0);
        do_load("sbyte_load", 3'd0, 1'b1, 9'h010, 1, 32'hFFFFFF81, 0, 0);
        do_load("ubyte_load", 3'd0, 1'b0, 9'h010, 1, 32'h00000081, 0, 0);
        do_load("shalf_pos", 3'd1, 1'b1, 9'h011, 2, 32'h00002233, 0, 0);
        do_load("shalf_neg", 3'd1, 1'b1, 9'h010, 2, 32'hFFFF8122, 0, 0);
        do_store("word_store", 3'd2, 9'h020, 4, 32'hDEADBEEF, 0, 0);
        do_store("byte_store", 3'd0, 9'h040, 1, 32'h12345678, 0, 0);
        do_store("half_store_wrap", 3'd1, 9'h1FF, 2, 32'h0000CAFE, 0, 0);
        do_load("half_load_wrap", 3'd1, 1'b0, 9'h1FF, 2, 32'h0000ABCD, 0, 0);
        do_load("stall_load", 3'd2, 1'b0, 9'h010, 4, 32'h81223344, 1, 3);
        do_store("stall_store", 3'd2, 9'h020, 4, 32'hDEADBEEF, 1, 3);

        // Reset during cycle 4 of a word store: only the first two strobes occur.
        issue(1'b1, 3'd2, 1'b0, 9'h030, 32'h11223344, a);
        wr_q.push_back('{addr: 9'h030, data: 8'h11, cyc: a + 1});
        wr_q.push_back('{addr: 9'h031, data: 8'h22, cyc: a + 3});
        while (cyc < a + 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_mem_write", 64'(mem_write), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (4) @(negedge clk);
        wait_done("midrst_store");
        last_rd = 32'd0;
        do_load("after_rst_load", 3'd0, 1'b0, 9'h010, 1, 32'h00000081, 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store sequencer for the next-generation robin CPU. It takes one memory request per transaction from the CPU execute stage (load or store, 1/2/…/WORD_BYTES bytes, signed or unsigned) and performs it as a big-endian sequence of byte accesses on the SoC's 8-bit memory port. Read latency is a parameter, and the memory can stall the sequence through `mem_ready`. Stores and loads get a one-cycle completion pulse, so the CPU can fetch while the unit is idle.

## Interface

Parameters:

- ADDR_WIDTH, 9, byte address width; addresses wrap modulo 2^ADDR_WIDTH
- WORD_BYTES, 4, bytes per CPU word (power of two, 1..8)
- RD_LAT, 2, cycles from registered `mem_raddr` to the `mem_data_out` capture edge (≥1)

Ports:

- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid&req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  $clog2(WORD_BYTES)+1  log2 of byte count; values above log2(WORD_BYTES) clamp to a full word
- req_signed  in  1  loads: sign-extend (1) or zero-extend (0)
- req_addr  in  ADDR_WIDTH  first (most significant) byte address
- req_wdata  in  8*WORD_BYTES  store data, right-aligned (low N bytes used)
- resp_valid  out  1  one-cycle completion pulse (load and store)
- resp_rdata  out  8*WORD_BYTES  extended load result, held until next load completes
- busy  out  1  ~req_ready
- mem_raddr  out  ADDR_WIDTH  read address
- mem_data_out  in  8  read data from memory
- mem_waddr  out  ADDR_WIDTH  write address
- mem_data_in  out  8  write data to memory
- mem_write  out  1  write strobe, one cycle per byte
- mem_ready  in  1  memory can complete a capture/write this cycle

## Operation

- States: IDLE, RD, WR_SETUP, WR_PULSE, RESP.
- IDLE: req_ready=1. On accept, latch size N=2^req_size (clamped), signed, write, wdata, and set byte index k=0.
  - Load: mem_raddr<=req_addr, go to RD.
  - Store: mem_waddr<=req_addr, mem_data_in<=most significant used byte, go to WR_SETUP.
- RD: the wait counter counts RD_LAT cycles.
  - On the final count, if mem_ready=1: shift mem_data_out into the assembly register (big-endian, first byte most significant), mem_raddr<=mem_raddr+1, k<=k+1, and restart the counter.
  - If mem_ready=0, hold and retry next cycle.
  - After byte N-1: resp_rdata<=extended value (sign bit = bit 7 of first byte when signed), go to RESP.
- WR_SETUP: if mem_ready=1, mem_write<=1 and go to WR_PULSE; otherwise hold.
- WR_PULSE: mem_write<=0.
  - If k=N-1, go to RESP.
  - Otherwise mem_waddr<=mem_waddr+1, mem_data_in<=next byte, k<=k+1, go to WR_SETUP.
- RESP: resp_valid=1 for this cycle only, then IDLE.
- Address increment wraps (0x1FF+1 → 0x000 at ADDR_WIDTH=9). No alignment is required.
- mem_write is never high for two consecutive cycles. mem_write and mem_raddr activity never overlap in one transaction.
- Requests while busy are ignored. No queueing.

## Timing

- Cycle 1 = first cycle after the accept edge. All outputs are registered except req_ready and busy, which decode state.
- Load, no stalls: byte k is captured at the end of cycle RD_LAT*(k+1). resp_valid is high in cycle RD_LAT*N+1.
- Store, no stalls: the byte k address/data are valid from cycle 2k+1. mem_write is high in cycle 2k+2. resp_valid is high in cycle 2N+1.
- Each mem_ready=0 cycle at a capture or strobe decision adds exactly one cycle.
- Back-to-back: a new request can be accepted in the cycle after resp_valid.
- Reset values: state IDLE, req_ready=1, busy=0, resp_valid=0, resp_rdata=0, mem_raddr=0, mem_waddr=0, mem_data_in=0, mem_write=0.
- Reset mid-transaction: the unit is IDLE at the next edge, mem_write=0, no resp_valid, and the partial load is discarded.

## Structure

- Shared package robin_pkg holds:
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2
  - the state enum
  - the extend(value, nbytes, signed) function, reused by the CPU for LOADB.
- No sub-module; single module mem_access_unit, instantiated by the CPU in place of its inline byte sequencing.

## Test plan

- Memory 0x10..0x13 = 81 22 33 44. Word load at 0x10, WORD_BYTES=4, RD_LAT=2 → resp_rdata=0x81223344 with resp_valid in cycle 9.
- Same memory. Signed byte load at 0x10 → 0xFFFFFF81. Unsigned byte load → 0x00000081. Signed half load at 0x11 → 0x00002233.
- Store 0xDEADBEEF at 0x20 → mem_write high in cycles 2,4,6,8 with waddr 0x20..0x23 and data DE,AD,BE,EF. resp_valid in cycle 9.
- Unsigned half load at 0x1FF with memory[0x1FF]=0xAB, [0x000]=0xCD → mem_raddr wraps to 0x000, resp_rdata=0x0000ABCD.
- mem_ready low for 3 cycles during byte 1 of a word load → resp_valid in cycle 12 with correct data. Repeat for a store → the mem_write pulse is delayed and never held high.
- Assert reset in cycle 4 of a word store → mem_write=0 from the next cycle, no resp_valid, req_ready=1. A new byte load then completes normally.
